// File: rtl/crossbar_pkg.sv
// Shared definitions for the 2x2 crossbar and its downstream slave targets.
//   CMD_READ / CMD_WRITE : encoding of the request command bit
//   slave_state_e        : slave memory FSM state encoding
//   XBAR_ADDR_W / XBAR_DATA_W : default slave-side address and data widths
package crossbar_pkg;

    localparam int unsigned XBAR_ADDR_W = 31;
    localparam int unsigned XBAR_DATA_W = 32;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_ACK     = 2'd2,
        S_RELEASE = 2'd3
    } slave_state_e;

endpackage

// File: rtl/crossbar_sram.sv
// Single-port synchronous RAM, DEPTH = 2**DEPTH_LOG2 words, registered read.
// Contents are not reset.
//   clock   : rising-edge clock
//   we_i    : write enable, writes wdata_i to addr_i at the edge
//   addr_i  : word address (shared by read and write)
//   wdata_i : write data
//   rdata_o : data at addr_i sampled at the previous edge (read-before-write)
module crossbar_sram #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clock,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/crossbar_slave_mem.sv
// Memory-mapped slave target on the downstream side of the 2x2 crossbar.
// Accepts a held request, waits LATENCY wait states, then commits the write
// or returns read data together with a single-cycle ack pulse.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   req          : request, held by the crossbar until after ack
//   cmd          : 1 = write, 0 = read
//   addr         : byte address, word index is addr[DEPTH_LOG2+1:2]
//   wdata        : write data
//   ack          : one-cycle completion pulse
//   rdata        : read data, nonzero only in the ack cycle of a read
//   busy         : high from accept until return to IDLE
//   state_o      : current FSM state (debug)
//
// Handshake: a transaction is accepted on an edge where req = 1 in IDLE.
// After ack the slave parks in RELEASE until it samples req = 0, so a held
// req can never start a second transaction.
module crossbar_slave_mem
    import crossbar_pkg::*;
#(
    parameter int unsigned ADDR_W     = XBAR_ADDR_W,
    parameter int unsigned DATA_W     = XBAR_DATA_W,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              cmd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output slave_state_e      state_o
);

    localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    slave_state_e          state_q;
    logic [3:0]            cnt_q;
    logic                  cmd_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  ack_q;
    logic                  busy_q;
    logic                  rd_sel_q;

    logic [DEPTH_LOG2-1:0] idx_in;
    logic                  enter_ack;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [DATA_W-1:0]     ram_wdata;
    logic [DATA_W-1:0]     ram_rdata;
    logic                  unused_addr_bits;

    assign idx_in           = addr[DEPTH_LOG2+1:2];
    assign unused_addr_bits = ^{addr[ADDR_W-1:DEPTH_LOG2+2], addr[1:0]};

    // The RAM access happens on the edge entering ACK. With LATENCY = 0 that
    // edge is the accept edge itself, so the live inputs are used in IDLE.
    assign enter_ack = ((state_q == S_IDLE) && req && (LATENCY == 0)) ||
                       ((state_q == S_WAIT) && (cnt_q == 4'd0));
    assign ram_addr  = (state_q == S_IDLE) ? idx_in : idx_q;
    assign ram_wdata = (state_q == S_IDLE) ? wdata : wdata_q;
    assign ram_we    = enter_ack &&
                       (((state_q == S_IDLE) ? cmd : cmd_q) == CMD_WRITE);

    crossbar_sram #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_sram (
        .clock   (clock),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            cmd_q    <= CMD_READ;
            idx_q    <= '0;
            wdata_q  <= '0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            ack_q    <= 1'b0;
            rd_sel_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        cmd_q   <= cmd;
                        idx_q   <= idx_in;
                        wdata_q <= wdata;
                        busy_q  <= 1'b1;
                        if (LATENCY == 0) begin
                            state_q  <= S_ACK;
                            ack_q    <= 1'b1;
                            rd_sel_q <= (cmd == CMD_READ);
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= WAIT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q  <= S_ACK;
                        ack_q    <= 1'b1;
                        rd_sel_q <= (cmd_q == CMD_READ);
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_ACK: begin
                    state_q <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (!req) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // rd_sel_q is set only for the ACK cycle of a read, keeping rdata zero
    // in every other cycle (including during reset).
    assign rdata   = rd_sel_q ? ram_rdata : '0;
    assign ack     = ack_q;
    assign busy    = busy_q;
    assign state_o = state_q;

endmodule

// File: doc/crossbar_slave_mem.md
Name: crossbar_slave_mem

Overview:
- Memory-mapped slave target on the downstream side of the 2x2 crossbar.
- One instance connects to each crossbar slave port (slave_0_* or slave_1_*).
- Accepts a held request, waits a programmable number of wait states, then commits the write or returns read data.
- Completes each transaction with a single-cycle ack pulse.

Parameters:
- ADDR_W, 31: width of the incoming address (byte address; the crossbar has already stripped the slave-select bit).
- DATA_W, 32: write and read data width.
- DEPTH_LOG2, 10: log2 of the number of memory words (1024 words).
- LATENCY, 2: wait-state cycles between accept and ack. Legal range 0..15.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  1  transaction request; held high by the crossbar until ack is seen
- cmd  input  1  1 = write, 0 = read; valid while req = 1
- addr  input  ADDR_W  byte address; valid while req = 1
- wdata  input  DATA_W  write data; valid while req = 1 and cmd = 1
- ack  output  1  single-cycle completion pulse
- rdata  output  DATA_W  read data; valid only in the ack cycle
- busy  output  1  high from accept until return to IDLE

Behaviour:
- Reset: clock is clock; reset is reset, asynchronous, active-high.
  - Reset values: ack = 0, rdata = 0, busy = 0, state = IDLE, wait counter = 0.
  - Memory contents are not cleared and are undefined after power-up.
- Word index: addr[DEPTH_LOG2+1:2]. addr[1:0] and addr bits above DEPTH_LOG2+1 are ignored, so upper addresses alias.
- States: IDLE, WAIT, ACK, RELEASE. All outputs are registered.
- IDLE:
  - On a clock edge with req = 1: capture cmd, word index and wdata into internal registers.
  - Next state is WAIT, with counter = LATENCY - 1, when LATENCY > 0.
  - Next state is ACK when LATENCY = 0.
  - busy goes to 1 at this edge.
- WAIT:
  - Counter decrements each cycle; at 0, next state is ACK.
  - req and all inputs are ignored; captured values are used.
- ACK (one cycle):
  - ack = 1.
  - Read: rdata = mem[captured index].
  - Write: mem[captured index] <= captured wdata at the edge entering ACK; rdata = 0.
  - Next state is RELEASE.
- Latency: ack is high exactly LATENCY+1 cycles after the edge that sampled req = 1 in IDLE.
- ack and rdata are 0 in every non-ACK cycle.
- RELEASE:
  - Waits for req = 0, because the crossbar's registered path keeps req high for cycles after ack.
  - On a sampled req = 0: next state is IDLE and busy <= 0.
  - A new transaction needs req low for at least one sampled cycle.
- Boundary conditions:
  - req dropping during WAIT does not abort the transaction; ack is still issued.
  - Changes to cmd/addr/wdata after accept have no effect.
  - Reset asserted in WAIT: the pending write is not committed, and ack never pulses.
  - Reset asserted coincident with the ACK cycle: the write may already be committed, and the bench must not check that location.
  - Read-after-write to the same index returns the new data: the write commits before the next accept is possible.
  - LATENCY = 0: ack follows accept by exactly 1 cycle.

Decomposition:
- Shared package crossbar_pkg holds:
  - CMD_READ = 1'b0 and CMD_WRITE = 1'b1
  - the slave FSM state encoding (IDLE, WAIT, ACK, RELEASE)
  - default ADDR_W / DATA_W shared with the crossbar
- Sub-module crossbar_sram: single-port synchronous RAM with one write-enable and a registered read, DEPTH = 2**DEPTH_LOG2.
  - Read is issued on entry to ACK so that data lands in the ACK cycle.
  - The FSM, counter and output registers stay in crossbar_slave_mem.

Test Plan:
- Write then read, LATENCY=2:
  - req=1, cmd=1, addr=0x0000_0010, wdata=0xDEADBEEF → ack pulses 3 cycles after accept, rdata=0.
  - req low 1 cycle, then read of 0x10 → ack after 3 cycles with rdata=0xDEADBEEF.
- LATENCY=0 instance: read of a previously written 0x4 = 0x12345678 → ack exactly 1 cycle after accept with rdata=0x12345678; busy high for 2+ cycles.
- req held high for 5 cycles after ack → exactly one ack; no second transaction until req is sampled 0.
- Aliasing: write 0xA5A5A5A5 to 0x0000_0000, read 0x0000_1000 (DEPTH_LOG2=10) → rdata=0xA5A5A5A5. addr[1:0]=3 reads the same word.
- Reset mid-WAIT: write 0x11111111 to 0x20 (previously 0x22222222), assert reset in the first WAIT cycle → no ack.
  - After reset, read 0x20 → 0x22222222.
  - Outputs are 0 during reset.
- Input changes during WAIT: accept a read of 0x10, then change addr to 0x14 and cmd to 1 → read data of 0x10 is returned and no write occurs.
